// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch front-panel controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} sw_state_t;

  localparam int SW_TW_DEFAULT = 4;

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-FF synchronizer, debounce counter and press detector.
// press_pulse is a registered single-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // The counter tracks consecutive synced samples that differ from the accepted level;
  // any sample agreeing with the accepted level restarts the qualification.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        pulse_q  <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller: debounced buttons drive a 4-state FSM that pulses the
// counter's toggle/reset inputs and freezes the display for lap splits.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TW              = SW_TW_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          btn_ss,
  input  logic          btn_lap,
  input  logic          btn_clr,
  input  logic [TW-1:0] timer_in,
  output logic          sw_toggle,
  output logic          sw_reset,
  output logic [TW-1:0] display,
  output logic          running,
  output logic          lap_active
);

  logic ss_ev;
  logic lap_ev;
  logic clr_ev;

  sw_state_t     state_q;
  logic          sw_toggle_q;
  logic          sw_reset_q;
  logic          running_q;
  logic          lap_active_q;
  logic [TW-1:0] lap_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
    .clk(clk), .reset_n(reset_n), .raw(btn_ss), .press_pulse(ss_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk(clk), .reset_n(reset_n), .raw(btn_lap), .press_pulse(lap_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .reset_n(reset_n), .raw(btn_clr), .press_pulse(clr_ev)
  );

  // sw_reset resets high so the counter is cleared once as reset releases.
  // Within a state only the events it acts on compete: clr beats ss beats lap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sw_toggle_q  <= 1'b0;
      sw_reset_q   <= 1'b1;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      lap_q        <= '0;
    end else begin
      sw_toggle_q <= 1'b0;
      sw_reset_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_ev) begin
            sw_reset_q <= 1'b1;
          end else if (ss_ev) begin
            state_q     <= RUN;
            sw_toggle_q <= 1'b1;
            running_q   <= 1'b1;
          end
        end
        RUN: begin
          if (ss_ev) begin
            state_q     <= PAUSE;
            sw_toggle_q <= 1'b1;
            running_q   <= 1'b0;
          end else if (lap_ev) begin
            state_q      <= LAP;
            lap_q        <= timer_in;
            lap_active_q <= 1'b1;
          end
        end
        LAP: begin
          if (ss_ev) begin
            state_q      <= PAUSE;
            sw_toggle_q  <= 1'b1;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
          end else if (lap_ev) begin
            state_q      <= RUN;
            lap_active_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (clr_ev) begin
            state_q    <= IDLE;
            sw_reset_q <= 1'b1;
          end else if (ss_ev) begin
            state_q     <= RUN;
            sw_toggle_q <= 1'b1;
            running_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sw_toggle  = sw_toggle_q;
  assign sw_reset   = sw_reset_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign display    = lap_active_q ? lap_q : timer_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized self-checking bench for stopwatch_ctrl with a sample-window reference
// model of the buttons and a behavioural counter standing in for the datapath.
module tb_stopwatch_ctrl;

  localparam int TW = 4;
  localparam int DC = 4;
  localparam int HL = DC + 2;

  logic          clk;
  logic          reset_n;
  logic          btnSs;
  logic          btnLap;
  logic          btnClr;
  logic [TW-1:0] timerCount;
  logic          sw_toggle;
  logic          sw_reset;
  logic [TW-1:0] display;
  logic          running;
  logic          lap_active;

  int checkCount;
  int errorCount;
  bit checkEn;

  bit            hist [3][HL];
  bit            lvl [3];
  bit            ev [3];
  bit            rawNow [3];
  bit            allSame;
  bit            mRun;
  bit            mPaused;
  bit            mLapped;
  bit            dpRun;
  logic [TW-1:0] lapVal;
  bit            expToggle;
  bit            expReset;

  stopwatch_ctrl #(.TW(TW), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_ss(btnSs),
    .btn_lap(btnLap),
    .btn_clr(btnClr),
    .timer_in(timerCount),
    .sw_toggle(sw_toggle),
    .sw_reset(sw_reset),
    .display(display),
    .running(running),
    .lap_active(lap_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model plus counter datapath. A button press is accepted when the window
  // of DC raw samples ending three edges back is uniform and differs from the last
  // accepted level; a rising acceptance is one event for the panel rules below.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        lvl[b] = 1'b0;
        ev[b]  = 1'b0;
        for (int j = 0; j < HL; j++) hist[b][j] = 1'b0;
      end
      mRun       = 1'b0;
      mPaused    = 1'b0;
      mLapped    = 1'b0;
      lapVal     = '0;
      dpRun      = 1'b0;
      expToggle  = 1'b0;
      expReset   = 1'b1;
      timerCount <= '0;
    end else begin
      if (sw_reset) begin
        timerCount <= '0;
        dpRun = 1'b0;
      end else begin
        if (dpRun) timerCount <= timerCount + 1'b1;
        if (sw_toggle) dpRun = !dpRun;
      end

      rawNow[0] = btnSs;
      rawNow[1] = btnLap;
      rawNow[2] = btnClr;
      for (int b = 0; b < 3; b++) begin
        allSame = 1'b1;
        for (int j = 3; j < HL; j++) if (hist[b][j] != hist[b][2]) allSame = 1'b0;
        ev[b] = 1'b0;
        if (allSame && hist[b][2] != lvl[b]) begin
          lvl[b] = hist[b][2];
          ev[b]  = hist[b][2];
        end
        for (int j = HL - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = rawNow[b];
      end

      expToggle = 1'b0;
      expReset  = 1'b0;
      if (!mRun && !mPaused) begin
        if (ev[2]) expReset = 1'b1;
        else if (ev[0]) begin mRun = 1'b1; expToggle = 1'b1; end
      end else if (mRun) begin
        if (ev[0]) begin
          mRun = 1'b0; mLapped = 1'b0; mPaused = 1'b1; expToggle = 1'b1;
        end else if (ev[1]) begin
          if (!mLapped) lapVal = timerCount;
          mLapped = !mLapped;
        end
      end else begin
        if (ev[2]) begin mPaused = 1'b0; expReset = 1'b1; end
        else if (ev[0]) begin mPaused = 1'b0; mRun = 1'b1; expToggle = 1'b1; end
      end
    end
  end

  // Every output is compared against the model on each falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("sw_toggle", sw_toggle, expToggle);
      checkOutput("sw_reset", sw_reset, expReset);
      checkOutput("running", running, mRun);
      checkOutput("lap_active", lap_active, mLapped);
      checkOutput("display", display, mLapped ? lapVal : timerCount);
    end
  end

  task automatic applyStimulus(input bit ss, input bit lap, input bit clr, input int hold, input int settle);
    @(negedge clk);
    btnSs = ss; btnLap = lap; btnClr = clr;
    repeat (hold) @(negedge clk);
    btnSs = 1'b0; btnLap = 1'b0; btnClr = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic countPulses(input int n, output int tog, output int rst);
    tog = 0; rst = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tog += int'(sw_toggle);
      rst += int'(sw_reset);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int lat, pulses, tog, rst;
    int holdLeft [3];
    checkCount = 0; errorCount = 0; checkEn = 1'b0;
    btnSs = 1'b0; btnLap = 1'b0; btnClr = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    checkEn = 1'b1;

    // Cycle 0 after release still carries the reset pulse, then it drops.
    @(negedge clk);
    checkOutput("rst_cycle0_sw_reset", sw_reset, 1);
    checkOutput("rst_display", display, 0);
    @(negedge clk);
    checkOutput("rst_cycle1_sw_reset", sw_reset, 0);
    checkOutput("rst_running", running, 0);

    // Held start/stop: exactly one toggle, DC+3 edges after the press.
    @(negedge clk);
    btnSs = 1'b1;
    lat = 0; pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (sw_toggle) begin pulses++; lat = i; end
      @(negedge clk);
      if (i == 10) btnSs = 1'b0;
    end
    checkOutput("ss_latency", lat, DC + 3);
    checkOutput("ss_pulses", pulses, 1);
    checkOutput("ss_running", running, 1);

    // Lap split freezes the display while the counter keeps going.
    applyStimulus(0, 1, 0, 6, 4);
    repeat (4) @(negedge clk);
    checkOutput("lap_active", lap_active, 1);
    checkOutput("lap_frozen", display, lapVal);
    applyStimulus(0, 1, 0, 6, 6);
    checkOutput("lap_release_active", lap_active, 0);
    checkOutput("lap_release_live", display, timerCount);

    // A glitch shorter than the debounce window must do nothing.
    fork
      applyStimulus(1, 0, 0, 2, 0);
      countPulses(14, tog, rst);
    join
    checkOutput("glitch_toggle", tog, 0);
    checkOutput("glitch_running", running, 1);

    // Pause, then clear and start/stop together: clear wins.
    applyStimulus(1, 0, 0, 6, 8);
    checkOutput("pause_running", running, 0);
    fork
      applyStimulus(1, 0, 1, 8, 0);
      countPulses(20, tog, rst);
    join
    checkOutput("clr_wins_toggle", tog, 0);
    checkOutput("clr_wins_reset", rst, 1);
    checkOutput("clr_wins_running", running, 0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(1, 0, 0, 6, 10);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_sw_reset", sw_reset, 1);
    checkOutput("async_sw_toggle", sw_toggle, 0);
    checkOutput("async_running", running, 0);
    checkOutput("async_lap", lap_active, 0);
    checkOutput("async_display", display, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Random button activity, including bounces and overlapping presses.
    for (int b = 0; b < 3; b++) holdLeft[b] = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
        if (holdLeft[b] == 0) begin
          holdLeft[b] = int'($urandom_range(1, 12));
          case (b)
            0: btnSs  = ($urandom_range(0, 2) == 0);
            1: btnLap = ($urandom_range(0, 2) == 0);
            default: btnClr = ($urandom_range(0, 3) == 0);
          endcase
        end else begin
          holdLeft[b]--;
        end
      end
      if (c == 1200) begin
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
      end
    end
    btnSs = 1'b0; btnLap = 1'b0; btnClr = 1'b0;
    repeat (20) @(negedge clk);

    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
